// File: rtl/lcd_i2c_writer_pkg.sv
// lcd_i2c_pkg: shared FSM states, PCF8574 bit map and I2C framing constants for lcd_i2c_writer
package lcd_i2c_pkg;
   typedef enum logic [2:0] {IDLE, START, BITS, STOP, DONE} state_t;
   localparam int PCF_RS = 0;
   localparam int PCF_RW = 1;
   localparam int PCF_EN = 2;
   localparam int PCF_BL = 3;
   localparam int PCF_D4 = 4;
   localparam int START_Q = 2;
   localparam int BITS_PER_BYTE = 9;
   localparam int NUM_BYTES = 5;
   localparam int STOP_Q = 3;
   function automatic logic [7:0] pcf_byte(input logic [3:0] nib, input logic en, input logic bl, input logic rs);
      logic [7:0] b;
      b = '0;
      b[PCF_D4 +: 4] = nib;
      b[PCF_BL] = bl;
      b[PCF_EN] = en;
      b[PCF_RW] = 1'b0;
      b[PCF_RS] = rs;
      return b;
   endfunction
endpackage

// File: rtl/lcd_i2c_writer_if.sv
// lcd_i2c_writer_if: sequencer handshake plus open-drain I2C pad controls of the LCD writer
interface lcd_i2c_writer_if;
   logic       ena_write;
   logic [7:0] data;
   logic       cmd_data;
   logic       done_write;
   logic       busy;
   logic       scl_oe;
   logic       sda_oe;
   logic       sda_in;
   logic       nack;
   modport master (output ena_write, data, cmd_data, sda_in, input done_write, busy, scl_oe, sda_oe, nack);
   modport slave (input ena_write, data, cmd_data, sda_in, output done_write, busy, scl_oe, sda_oe, nack);
endinterface

// File: rtl/lcd_i2c_writer_tick.sv
// lcd_i2c_tick: pulses tick on the last cycle of every SCL quarter; clr holds the count at zero
module lcd_i2c_tick #(
   parameter int unsigned QUARTER = 3
) (
   input  logic clk_1MHz,
   input  logic rst,
   input  logic clr,
   output logic tick
);
   logic [7:0] cnt_q, cnt_d;
   assign tick = !clr && cnt_q == 8'(QUARTER - 1);
   // next count: restart on wrap or clear
   always_comb cnt_d = (clr || tick) ? '0 : cnt_q + 8'd1;
   // count register
   always_ff @(posedge clk_1MHz or posedge rst)
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/lcd_i2c_writer.sv
// lcd_i2c_writer: sends one LCD byte as a 4-bit PCF8574 I2C write; LCD_I2C_ACK_CHECK_EN enables NACK abort
module lcd_i2c_writer #(
   parameter logic [6:0]  I2C_ADDR  = 7'h27,
   parameter int unsigned QUARTER   = 3,
   parameter bit          BACKLIGHT = 1'b1
) (
   input logic clk_1MHz,
   input logic rst,
   lcd_i2c_writer_if.slave bus
);
   import lcd_i2c_pkg::*;
   state_t state_q, state_d;
   logic [1:0] phase_q, phase_d;
   logic [3:0] bit_q, bit_d;
   logic [2:0] byte_q, byte_d;
   logic [7:0] data_q, data_d, cur_byte;
   logic rs_q, rs_d, busy_q, busy_d, done_q, done_d, nack_q, nack_d;
   logic tick, ack_fail, scl_oe, sda_oe;
   lcd_i2c_tick #(.QUARTER(QUARTER)) u_tick (
      .clk_1MHz(clk_1MHz),
      .rst(rst),
      .clr(state_q == IDLE || state_q == DONE),
      .tick(tick)
   );
   assign cur_byte = byte_q == 3'd0 ? {I2C_ADDR, 1'b0}
                   : pcf_byte(byte_q < 3'd3 ? data_q[7:4] : data_q[3:0], byte_q[0], BACKLIGHT, rs_q);
`ifdef LCD_I2C_ACK_CHECK_EN
   assign ack_fail = state_q == BITS && tick && phase_q == 2'd2 && bit_q == 4'(BITS_PER_BYTE - 1) && bus.sda_in;
`else
   assign ack_fail = 1'b0;
`endif
   // sequencing of START, 45 bit slots and STOP, one quarter per tick
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      data_d  = data_q;
      rs_d    = rs_q;
      nack_d  = nack_q;
      done_d  = 1'b0;
      busy_d  = done_q ? 1'b0 : busy_q;
      case (state_q)
         IDLE: if (bus.ena_write && !busy_q) begin
            state_d = START;
            data_d  = bus.data;
            rs_d    = bus.cmd_data;
            busy_d  = 1'b1;
            phase_d = '0;
            bit_d   = '0;
            byte_d  = '0;
         end
         START: if (tick) begin
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'(START_Q - 1)) begin
               state_d = BITS;
               phase_d = '0;
            end
         end
         BITS: if (ack_fail) begin
            state_d = STOP;
            phase_d = '0;
            nack_d  = 1'b1;
         end else if (tick) begin
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd3) begin
               if (bit_q == 4'(BITS_PER_BYTE - 1)) begin
                  bit_d = '0;
                  if (byte_q == 3'(NUM_BYTES - 1)) state_d = STOP;
                  else byte_d = byte_q + 3'd1;
               end else bit_d = bit_q + 4'd1;
            end
         end
         STOP: if (tick) begin
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'(STOP_Q - 1)) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   // open-drain line drive decoded from state and quarter; ACK slots release SDA
   always_comb begin
      scl_oe = 1'b0;
      sda_oe = 1'b0;
      case (state_q)
         START: begin
            sda_oe = 1'b1;
            scl_oe = phase_q[0];
         end
         BITS: begin
            scl_oe = !phase_q[1];
            sda_oe = bit_q != 4'(BITS_PER_BYTE - 1) && !cur_byte[3'd7 - bit_q[2:0]];
         end
         STOP: begin
            scl_oe = phase_q == 2'd0;
            sda_oe = phase_q != 2'd2;
         end
         default: ;
      endcase
   end
   // state registers; reset drops everything and releases the bus without a STOP
   always_ff @(posedge clk_1MHz or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         phase_q <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         data_q  <= '0;
         rs_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         nack_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         data_q  <= data_d;
         rs_q    <= rs_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         nack_q  <= nack_d;
      end
   assign bus.scl_oe     = scl_oe;
   assign bus.sda_oe     = sda_oe;
   assign bus.busy       = busy_q;
   assign bus.done_write = done_q;
   assign bus.nack       = nack_q;
endmodule

// File: tb/tb_lcd_i2c_writer.sv
// tb_lcd_i2c_writer: randomized scoreboard bench with an I2C bus decoder for lcd_i2c_writer
module tb_lcd_i2c_writer;
   localparam int QUARTER = 3;
   localparam logic [6:0] ADDR = 7'h27;
   localparam int BL = 1;
`ifdef LCD_I2C_ACK_CHECK_EN
   localparam bit NACK_ABORTS = 1'b1;
`else
   localparam bit NACK_ABORTS = 1'b0;
`endif
   logic clk_1MHz = 1'b0;
   logic rst = 1'b1;
   int checks = 0, errors = 0, cyc = 0;
   logic [7:0] exp_bytes[$];
   int exp_done[$];
   logic exp_nack[$];
   logic ps = 1'b1, pd = 1'b1, in_txn = 1'b0, ack_pull = 1'b0, ack_en = 1'b1, prev_done = 1'b0;
   int bitcnt = 0;
   logic [7:0] sh = '0;
   lcd_i2c_writer_if bus();
   lcd_i2c_writer #(.I2C_ADDR(ADDR), .QUARTER(QUARTER), .BACKLIGHT(1'b1)) dut (
      .clk_1MHz(clk_1MHz),
      .rst(rst),
      .bus(bus)
   );
   assign bus.sda_in = !bus.sda_oe && !ack_pull;
   always #5 clk_1MHz = ~clk_1MHz;
   always @(posedge clk_1MHz) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // reference model: expected expander bytes, latency in quarters and nack outcome
   task automatic push_txn(input logic [7:0] d, input logic c, input bit abort);
      int nib[4];
      int quarters;
      nib = '{d / 16, d / 16, d % 16, d % 16};
      exp_bytes.push_back(8'(ADDR * 2));
      if (!abort)
         for (int k = 0; k < 4; k++) exp_bytes.push_back(8'(nib[k] * 16 + BL * 8 + (k % 2 == 0 ? 4 : 0) + c));
      quarters = abort ? 2 + 9 * 4 - 1 + 3 : 2 + 5 * 9 * 4 + 3;
      exp_done.push_back(cyc + 2 + quarters * QUARTER);
      exp_nack.push_back(abort);
   endtask

   task automatic send(input logic [7:0] d, input logic c, input bit abort);
      @(negedge clk_1MHz);
      push_txn(d, c, abort);
      bus.ena_write = 1'b1;
      bus.data = d;
      bus.cmd_data = c;
      @(negedge clk_1MHz);
      bus.ena_write = 1'b0;
      chk("busy_after_accept", bus.busy, 1);
   endtask

   task automatic wait_done();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clk_1MHz);
         got = bus.done_write;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL done_timeout got no done_write expected one within 3000 cycles");
         exp_bytes.delete();
         exp_done.delete();
         exp_nack.delete();
      end
   endtask

   // bus decoder and done monitor: pops the scoreboard whenever the DUT presents a byte or done
   always @(negedge clk_1MHz) begin
      logic s, d;
      s = !bus.scl_oe;
      d = !bus.sda_oe;
      if (rst) begin
         in_txn = 1'b0;
         bitcnt = 0;
         ack_pull = 1'b0;
         prev_done = 1'b0;
      end else begin
         if (ps && s && pd && !d) begin
            chk("start_legal", in_txn, 0);
            in_txn = 1'b1;
            bitcnt = 0;
         end else if (ps && s && !pd && d) begin
            chk("stop_legal", {in_txn, 4'(bitcnt)}, {1'b1, 4'd1});
            in_txn = 1'b0;
            bitcnt = 0;
         end else if (!ps && s && in_txn) begin
            chk("sda_at_rise", d, pd);
            if (bitcnt < 8) begin
               sh = {sh[6:0], d};
               bitcnt++;
               if (bitcnt == 8) begin
                  if (exp_bytes.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL byte_unexpected got %h expected none", sh);
                  end else chk("byte", sh, exp_bytes.pop_front());
               end
            end else bitcnt = 0;
         end
         if (!s) ack_pull = ack_en && in_txn && bitcnt == 8;
         if (prev_done) chk("busy_after_done", bus.busy, 0);
         if (bus.done_write) begin
            if (exp_done.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL done_unexpected got done at cycle %0d expected none", cyc);
            end else begin
               chk("done_cycle", cyc, exp_done.pop_front());
               chk("nack_at_done", bus.nack, exp_nack.pop_front());
               chk("busy_at_done", bus.busy, 1);
               chk("lines_at_done", {bus.scl_oe, bus.sda_oe}, 0);
            end
         end
         prev_done = bus.done_write;
      end
      ps = s;
      pd = d;
   end

   initial begin
      bus.ena_write = 1'b0;
      bus.data = '0;
      bus.cmd_data = 1'b0;
      repeat (3) @(negedge clk_1MHz);
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_1MHz);
         chk("idle", {bus.scl_oe, bus.sda_oe, bus.done_write, bus.busy, bus.nack}, 0);
      end
      send(8'h28, 1'b0, 1'b0);
      wait_done();
      bus.ena_write = 1'b1;
      bus.data = 8'hA5;
      @(negedge clk_1MHz);
      bus.ena_write = 1'b0;
      @(negedge clk_1MHz);
      chk("ena_in_done_cycle_ignored", bus.busy, 0);
      send(8'h41, 1'b1, 1'b0);
      repeat (98) @(negedge clk_1MHz);
      bus.ena_write = 1'b1;
      bus.data = 8'h5A;
      @(negedge clk_1MHz);
      bus.ena_write = 1'b0;
      chk("busy_second_req", bus.busy, 1);
      wait_done();
      for (int i = 0; i < 6; i++) begin
         send(8'($urandom), 1'($urandom), 1'b0);
         wait_done();
         repeat ($urandom_range(0, 5)) @(negedge clk_1MHz);
      end
      send(8'($urandom), 1'($urandom), 1'b0);
      repeat (199) @(negedge clk_1MHz);
      #1 rst = 1'b1;
      #1 chk("lines_on_reset", {bus.scl_oe, bus.sda_oe, bus.busy}, 0);
      exp_bytes.delete();
      exp_done.delete();
      exp_nack.delete();
      repeat (3) @(negedge clk_1MHz);
      rst = 1'b0;
      send(8'h0C, 1'b0, 1'b0);
      wait_done();
      ack_en = 1'b0;
      send(8'($urandom), 1'($urandom), NACK_ABORTS);
      wait_done();
      repeat (5) @(negedge clk_1MHz);
      chk("nack_final", bus.nack, NACK_ABORTS);
      chk("bytes_left", exp_bytes.size(), 0);
      chk("done_left", exp_done.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
